// File: rtl/pcpu_fetch_unit.sv
// Instruction-fetch front end: credit-limited requests to a variable-latency memory,
// an in-order instruction queue toward ID, and redirect flush with stale-response dropping.
module pcpu_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter int                QDEPTH   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_gnt,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              id_valid,
   output logic [INST_W-1:0] id_inst,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc4,
   input  logic              id_ready
);

   localparam int PW  = $clog2(QDEPTH);
   localparam int CW  = PW + 1;
   localparam int CW1 = CW + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [INST_W-1:0] inst_q [QDEPTH];
   logic [INST_W-1:0] inst_d [QDEPTH];
   logic [ADDR_W-1:0] pc_q [QDEPTH];
   logic [ADDR_W-1:0] pc_d [QDEPTH];

   logic [CW:0]       in_flight;
   logic              grant;
   logic              rsp;
   logic              pop;
   logic              push;
   logic [ADDR_W-1:0] target_pc;

   // Queue slots are reserved at request time, so an accepted response never overflows.
   always_comb begin
      in_flight = {1'b0, count_q} + {1'b0, outstanding_q};
      imem_req  = !rst && !redirect && (in_flight < CW1'(QDEPTH));
      imem_addr = fetch_pc_q;
      grant     = imem_req && imem_gnt;
      rsp       = imem_rvalid && (outstanding_q != '0);
      pop       = (count_q != '0) && id_ready;
      push      = rsp && !redirect && (drop_cnt_q == '0);
      target_pc = redirect_pc & ~ADDR_W'(3);

      fetch_pc_d    = grant ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
      drop_cnt_d    = drop_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      inst_d        = inst_q;
      pc_d          = pc_q;

      if (redirect) begin
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         count_d    = '0;
         rd_ptr_d   = wr_ptr_q;
         drop_cnt_d = outstanding_q - CW'(rsp);
      end else begin
         if (rsp && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
         if (push) begin
            inst_d[wr_ptr_q] = imem_rdata;
            pc_d[wr_ptr_q]   = resp_pc_q;
            resp_pc_d        = resp_pc_q + ADDR_W'(4);
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            inst_q[i] <= '0;
            pc_q[i]   <= RESET_PC;
         end
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         inst_q        <= inst_d;
         pc_q          <= pc_d;
      end
   end

   assign id_valid = (count_q != '0);
   assign id_inst  = inst_q[rd_ptr_q];
   assign id_pc    = pc_q[rd_ptr_q];
   assign id_pc4   = pc_q[rd_ptr_q] + ADDR_W'(4);

endmodule

// File: tb/tb_pcpu_fetch_unit.sv
// Bench for pcpu_fetch_unit: an in-order memory model plus a queue-level reference
// of the fetch stream, checked every cycle, with directed scenarios pinning literal values.
module tb_pcpu_fetch_unit;

   localparam int          QD  = 4;
   localparam logic [31:0] RPC = 32'h0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_ready = 1'b0;

   pcpu_fetch_unit #(.ADDR_W(32), .INST_W(32), .QDEPTH(QD), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
      .id_ready(id_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Reference: the pcs waiting for ID, plus fetch/response addresses and in-flight bookkeeping.
   logic [31:0] mQ[$];
   logic [31:0] mFetch = RPC;
   logic [31:0] mResp = RPC;
   int          mOut = 0;
   int          mDrop = 0;

   logic [31:0] memAddr[$];
   int          memDue[$];
   int          memLat = 1;
   bit          memStall = 1'b0;

   function automatic logic [31:0] image(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic bit expReq();
      return !redirect && ((mQ.size() + mOut) < QD);
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkOutput();
      cmp("imem_req", imem_req, expReq());
      cmp("imem_addr", imem_addr, mFetch);
      cmp("id_valid", id_valid, mQ.size() != 0);
      if (mQ.size() != 0) begin
         cmp("id_pc", id_pc, mQ[0]);
         cmp("id_inst", id_inst, image(mQ[0]));
         cmp("id_pc4", id_pc4, mQ[0] + 32'd4);
      end
      assert (!(imem_rvalid && mOut == 0)) else $error("[TB] rvalid with nothing outstanding");
   endtask

   task automatic applyStimulus(input bit g, input bit rdy, input bit rd, input logic [31:0] rpc);
      @(negedge clk);
      imem_gnt    = g;
      id_ready    = rdy;
      redirect    = rd;
      redirect_pc = rpc;
      if (memAddr.size() != 0 && memDue[0] <= cyc && !memStall) begin
         imem_rvalid = 1'b1;
         imem_rdata  = image(memAddr[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      #1;
      checkOutput();
   endtask

   task automatic advance();
      bit grant, rv, pop;
      grant = expReq() && imem_gnt;
      rv    = imem_rvalid && (mOut > 0);
      pop   = (mQ.size() != 0) && id_ready;
      @(posedge clk);
      if (imem_rvalid) begin
         void'(memAddr.pop_front());
         void'(memDue.pop_front());
      end
      if (grant) begin
         memAddr.push_back(mFetch);
         memDue.push_back(cyc + memLat);
      end
      if (redirect) begin
         mQ.delete();
         mDrop  = mOut - int'(rv);
         mOut   = mOut - int'(rv);
         mFetch = {redirect_pc[31:2], 2'b00};
         mResp  = mFetch;
      end else begin
         if (pop) void'(mQ.pop_front());
         if (rv) begin
            if (mDrop > 0) mDrop--;
            else begin
               mQ.push_back(mResp);
               mResp += 32'd4;
            end
         end
         mOut = mOut + int'(grant) - int'(rv);
         if (grant) mFetch += 32'd4;
      end
      cyc++;
   endtask

   task automatic step(input bit g, input bit rdy, input bit rd, input logic [31:0] rpc);
      applyStimulus(g, rdy, rd, rpc);
      advance();
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      redirect = 1'b0;
      imem_rvalid = 1'b0;
      imem_gnt = 1'b0;
      id_ready = 1'b0;
      memStall = 1'b0;
      #1;
      cmp("rst imem_req", imem_req, 0);
      cmp("rst id_valid", id_valid, 0);
      cmp("rst id_inst", id_inst, 0);
      cmp("rst id_pc", id_pc, RPC);
      mQ.delete();
      memAddr.delete();
      memDue.delete();
      mFetch = RPC;
      mResp  = RPC;
      mOut   = 0;
      mDrop  = 0;
      @(negedge clk);
      cmp("rst held imem_req", imem_req, 0);
      rst = 1'b0;
   endtask

   initial begin
      int  grants;
      bit  seen;
      logic [31:0] rpc;

      // Steady stream: one instruction per cycle with a one-cycle memory.
      doReset();
      memLat = 1;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1, 1, 0, 0);
         cmp("ss imem_addr", imem_addr, 32'(4 * k));
         if (k >= 2) begin
            cmp("ss id_valid", id_valid, 1);
            cmp("ss id_pc", id_pc, 32'(4 * (k - 2)));
         end
         advance();
      end

      // ID stalled: the queue fills with exactly QD entries, then drains in order.
      doReset();
      grants = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1, 0, 0, 0);
         if (imem_req) grants++;
         advance();
      end
      cmp("stall grants", grants, QD);
      applyStimulus(1, 0, 0, 0);
      cmp("stall imem_req", imem_req, 0);
      cmp("stall head pc", id_pc, 32'h0);
      advance();
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 1, 0, 0);
         cmp("drain pc", id_pc, 32'(4 * k));
         if (imem_req && !seen) begin
            cmp("resume addr", imem_addr, 32'h10);
            seen = 1'b1;
         end
         advance();
      end
      cmp("resume seen", seen, 1);

      // Grant withheld: address must hold and be fetched exactly once.
      doReset();
      step(1, 1, 0, 0);
      step(1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 1, 0, 0);
         cmp("nogn imem_req", imem_req, 1);
         cmp("nogn imem_addr", imem_addr, 32'h8);
         advance();
      end
      applyStimulus(1, 1, 0, 0);
      cmp("gnt addr", imem_addr, 32'h8);
      advance();
      applyStimulus(1, 1, 0, 0);
      cmp("after gnt addr", imem_addr, 32'hC);
      advance();

      // Redirect while slow responses are in flight.
      doReset();
      memLat = 3;
      for (int k = 0; k < 40 && mFetch != 32'h18; k++) step(1, 1, 0, 0);
      step(1, 1, 1, 32'h103);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         applyStimulus(1, 1, 0, 0);
         if (id_valid) begin
            cmp("redir target pc", id_pc, 32'h100);
            seen = 1'b1;
         end
         advance();
      end
      cmp("redir target seen", seen, 1);

      // Redirect coinciding with a response and a pop.
      doReset();
      memLat = 1;
      for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
      step(1, 1, 1, 32'h200);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         applyStimulus(1, 1, 0, 0);
         if (id_valid) begin
            cmp("redir2 target pc", id_pc, 32'h200);
            seen = 1'b1;
         end
         advance();
      end
      cmp("redir2 target seen", seen, 1);

      // Reset mid-operation discards queue and in-flight requests.
      memLat = 2;
      for (int k = 0; k < 4; k++) step(1, 0, 0, 0);
      doReset();
      applyStimulus(1, 1, 0, 0);
      cmp("post-rst addr", imem_addr, RPC);
      advance();

      // Randomized traffic, including redirects near the top of the address space.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 499) == 0) doReset();
         memLat   = $urandom_range(1, 4);
         memStall = ($urandom_range(0, 3) == 0);
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 + 32'($urandom_range(0, 15))) : $urandom;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 19) == 0, rpc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pcpu_fetch_unit.md
Name: pcpu_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation pipelined CPU. Replaces the single-register PC and IF/ID latch.
- Decouples fetch from decode with an instruction queue of QDEPTH entries.
- Talks to a variable-latency instruction memory over a req/gnt/rvalid handshake, with up to QDEPTH requests in flight.
- Handles redirects (branch/jump/jr resolved in ID) by flushing the queue and discarding stale in-flight responses.

Parameters:
ADDR_W, 32, instruction address width
INST_W, 32, instruction width
QDEPTH, 4, queue depth and max in-flight requests (power of 2, >=2)
RESET_PC, 0, fetch address after reset (word aligned)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address; bits [1:0] always 0
imem_gnt  in  1  memory accepts request this cycle (only meaningful with imem_req)
imem_rvalid  in  1  response valid; responses return in request order, >=1 cycle after grant
imem_rdata  in  INST_W  response instruction
redirect  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored, treated as 0
id_valid  out  1  queue head valid
id_inst  out  INST_W  queue head instruction
id_pc  out  ADDR_W  address of id_inst
id_pc4  out  ADDR_W  id_pc + 4, wraps modulo 2^ADDR_W
id_ready  in  1  ID consumes head this cycle; 0 = stall

Behaviour:
- State:
  - fetch_pc: next address to request.
  - resp_pc: address of next accepted response.
  - Queue occupancy count: 0..QDEPTH.
  - outstanding: granted, not yet returned, 0..QDEPTH.
  - drop_cnt: responses still to be discarded.
- Reset values: fetch_pc = resp_pc = RESET_PC; count, outstanding, drop_cnt = 0.
  - Outputs during/after reset: imem_req = 0 during rst, id_valid = 0, id_inst = 0, id_pc = RESET_PC.
  - Reset mid-operation discards everything; the memory shares rst.
- Request: imem_req = !redirect && (count + outstanding < QDEPTH). imem_addr = fetch_pc.
  - On imem_req && imem_gnt: fetch_pc += 4, outstanding += 1.
  - Without gnt, imem_addr is held stable. imem_req is withdrawn only by redirect or reset.
- Credit rule guarantees no overflow: an accepted response always has a free slot.
- Response: on imem_rvalid, outstanding -= 1.
  - If drop_cnt != 0: drop_cnt -= 1 and discard the response.
  - Else: enqueue {imem_rdata, resp_pc}, then resp_pc += 4.
  - rvalid with outstanding == 0 is a protocol error: ignored, flagged by a bench assertion.
- Decode side: id_valid = (count != 0). id_inst/id_pc come from registered queue storage; no combinational path from imem_rdata.
  - On id_valid && id_ready: pop.
  - Push and pop in the same cycle keep count unchanged.
  - id_ready = 0 holds head outputs stable.
- Latency: response accepted at cycle t is visible on id_* at cycle t+1. Steady state with 1-cycle memory and id_ready = 1 sustains one instruction per cycle.
- Redirect, in one cycle, with priority over push:
  - Pop in the same cycle is honoured; that head is the branch itself.
  - All remaining queue entries are flushed; count = 0 next cycle.
  - An rvalid in the redirect cycle is discarded.
  - drop_cnt <= outstanding - imem_rvalid. outstanding is updated normally.
  - fetch_pc <= resp_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - imem_req is 0 in the redirect cycle; requesting resumes the next cycle if credit allows.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Wrap-around:
  - fetch_pc and resp_pc wrap modulo 2^ADDR_W.
  - Queue pointers wrap modulo QDEPTH.
  - Counter widths are clog2(QDEPTH)+1.

Test Plan:
- Reset, then gnt = 1 always, rvalid 1 cycle after grant, id_ready = 1 → imem_addr 0, 4, 8, …; id_pc 0, 4, 8, … one per cycle; id_inst matches memory image; id_pc4 = id_pc + 4.
- QDEPTH = 4, id_ready = 0 → exactly 4 grants (0x0–0xC), then imem_req = 0; count = 4; head stays id_pc = 0. Raise id_ready → pc 0, 4, 8, C drain in order, fetching resumes at 0x10.
- gnt = 0 for 3 cycles at addr 0x8 → imem_req = 1 and imem_addr = 0x8 stable throughout; one grant, no duplicate fetch.
- Memory latency 3, two requests in flight (0x10, 0x14), redirect to 0x103 → next id_pc = 0x100. Both stale responses are dropped; drop_cnt returns to 0.
- Redirect in the same cycle as rvalid and id_valid && id_ready → popped head consumed once, arriving response discarded, next id_valid instruction has pc = redirect target.
- Assert rst with 3 entries queued and 2 outstanding → next cycle id_valid = 0, imem_req = 0 while rst high. After release, fetch restarts at RESET_PC.
